fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter_pkg.sv | 47 ++++
 rtl/fp_mul_arbiter_mul.sv | 113 +++++++++++
 rtl/fp_mul_arbiter.sv | 157 +++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_arbiter_pkg.sv
// Shared FP64 definitions: operand type, rounding modes, result flags and
// the rounding decision helpers used by the multiplier datapath.
package fp_mul_arbiter_pkg;

    typedef logic [63:0] fp64_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic sign_exe;
        logic inf;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    localparam logic [10:0] EXP_ALL1 = 11'h7FF;
    localparam int          EXP_BIAS = 1023;
    localparam fp64_t       QNAN     = 64'h7FF8_0000_0000_0000;

    // Unknown encodings fall back to round-to-nearest-even.
    function automatic logic round_up(input rm_e rm, input logic sign, input logic lsb,
                                      input logic guard, input logic sticky);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (guard | sticky);
            RM_RUP:  return !sign & (guard | sticky);
            RM_RMM:  return guard;
            default: return guard & (sticky | lsb);
        endcase
    endfunction

    function automatic logic ovf_to_inf(input rm_e rm, input logic sign);
        case (rm)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign;
            RM_RUP:  return !sign;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fp_mul_arbiter_mul.sv
// Pipelined FP64 multiplier: LAT ce-gated result stages; flags leave FSKEW
// stages early. Subnormal operands and results are flushed to signed zero.
module fpMultiply64nr
    import fp_mul_arbiter_pkg::*;
#(
    parameter int LAT   = 8,
    parameter int FSKEW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  fp64_t      a,
    input  fp64_t      b,
    input  logic [2:0] rm,
    output fp64_t      res,
    output fp_flags_t  flags
);
    localparam int FLAT = LAT - FSKEW;

    logic               sign, a_zero, b_zero, a_inf, b_inf, nan_in;
    logic [105:0]       prod;
    logic [52:0]        mant;
    logic               guard, sticky;
    logic [53:0]        mant_r;
    logic signed [13:0] exp_s;
    fp64_t              res_c;
    fp_flags_t          flags_c;

    fp64_t     [LAT-1:0]  res_pipe_q, res_pipe_d;
    fp_flags_t [FLAT-1:0] flg_pipe_q, flg_pipe_d;

    always_comb begin
        sign   = a[63] ^ b[63];
        a_zero = (a[62:52] == 11'd0);
        b_zero = (b[62:52] == 11'd0);
        a_inf  = (a[62:52] == EXP_ALL1) && (a[51:0] == 52'd0);
        b_inf  = (b[62:52] == EXP_ALL1) && (b[51:0] == 52'd0);
        nan_in = ((a[62:52] == EXP_ALL1) && (a[51:0] != 52'd0)) ||
                 ((b[62:52] == EXP_ALL1) && (b[51:0] != 52'd0)) ||
                 (a_inf && b_zero) || (b_inf && a_zero);

        prod  = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
        exp_s = 14'(a[62:52]) + 14'(b[62:52]) - 14'(EXP_BIAS) + 14'(prod[105]);

        if (prod[105]) begin
            mant   = prod[105:53];
            guard  = prod[52];
            sticky = |prod[51:0];
        end else begin
            mant   = prod[104:52];
            guard  = prod[51];
            sticky = |prod[50:0];
        end

        // A carry out of rounding leaves mantissa 1.0, so bump the exponent.
        mant_r = {1'b0, mant} + 54'(round_up(rm_e'(rm), sign, mant[0], guard, sticky));
        if (mant_r[53]) begin
            exp_s = exp_s + 14'sd1;
        end

        flags_c = '0;
        res_c   = {sign, exp_s[10:0], mant_r[53] ? mant_r[52:1] : mant_r[51:0]};
        if (nan_in) begin
            res_c            = QNAN;
            flags_c.sign_exe = 1'b1;
        end else if (a_inf || b_inf) begin
            res_c       = {sign, EXP_ALL1, 52'd0};
            flags_c.inf = 1'b1;
        end else if (a_zero || b_zero) begin
            res_c = {sign, 63'd0};
        end else if (exp_s >= 14'sd2047) begin
            flags_c.overflow = 1'b1;
            if (ovf_to_inf(rm_e'(rm), sign)) begin
                res_c       = {sign, EXP_ALL1, 52'd0};
                flags_c.inf = 1'b1;
            end else begin
                res_c = {sign, 11'h7FE, {52{1'b1}}};
            end
        end else if (exp_s <= 14'sd0) begin
            res_c             = {sign, 63'd0};
            flags_c.underflow = 1'b1;
        end
    end

    always_comb begin
        res_pipe_d = res_pipe_q;
        flg_pipe_d = flg_pipe_q;
        if (ce) begin
            res_pipe_d[0] = res_c;
            flg_pipe_d[0] = flags_c;
            for (int i = 1; i < LAT; i++) begin
                res_pipe_d[i] = res_pipe_q[i-1];
            end
            for (int i = 1; i < FLAT; i++) begin
                flg_pipe_d[i] = flg_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_pipe_q <= '0;
            flg_pipe_q <= '0;
        end else begin
            res_pipe_q <= res_pipe_d;
            flg_pipe_q <= flg_pipe_d;
        end
    end

    assign res   = res_pipe_q[LAT-1];
    assign flags = flg_pipe_q[FLAT-1];

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one pipelined FP64 multiplier among NREQ requesters with result backpressure.
// Define FP_MUL_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module fp_mul_arbiter
    import fp_mul_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LAT   = 8,
    parameter int FSKEW = 1,
    localparam int TAG_W = $clog2(NREQ),
    localparam int CNT_W = $clog2(LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][63:0] req_a,
    input  logic [NREQ-1:0][63:0] req_b,
    input  logic [NREQ-1:0][2:0]  req_rm,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [TAG_W-1:0]      res_tag,
    output logic [63:0]           res_o,
    output logic [3:0]            res_flags,
    output logic [CNT_W-1:0]      inflight
);
    logic                      ce, issue, retire, any_valid;
    logic [TAG_W-1:0]          start_idx, winner, cand;
    int                        arb_idx;
    logic [LAT-1:0]            vld_q, vld_d;
    logic [LAT-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]          inflight_q, inflight_d;
    fp64_t                     mul_res;
    fp_flags_t                 mul_flags;

    assign res_valid = vld_q[LAT-1];
    assign res_tag   = tag_q[LAT-1];
    assign res_o     = mul_res;
    assign inflight  = inflight_q;
    assign ce        = !res_valid || res_ready;
    assign issue     = |(req_valid & req_ready);
    assign retire    = res_valid && res_ready;

    // Scan from the farthest offset down so the candidate nearest start_idx wins.
    always_comb begin
        arb_idx   = 0;
        cand      = '0;
        winner    = '0;
        any_valid = |req_valid;
        for (int off = NREQ - 1; off >= 0; off--) begin
            arb_idx = int'(start_idx) + off;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            cand = TAG_W'(arb_idx);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
        req_ready = '0;
        if (rst_n && ce && any_valid) begin
            req_ready[winner] = 1'b1;
        end
    end

`ifdef FP_MUL_ARB_RR_EN
    logic [TAG_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (winner == TAG_W'(NREQ - 1)) ? '0 : winner + TAG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start_idx = ptr_q;
`else
    assign start_idx = '0;
`endif

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (ce) begin
            vld_d[0] = issue;
            tag_d[0] = issue ? winner : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
        end
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            tag_q      <= '0;
            inflight_q <= '0;
        end else begin
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    fpMultiply64nr #(
        .LAT   (LAT),
        .FSKEW (FSKEW)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .a     (req_a[winner]),
        .b     (req_b[winner]),
        .rm    (req_rm[winner]),
        .res   (mul_res),
        .flags (mul_flags)
    );

    // The multiplier's flags run ahead of its result; re-align them here.
    generate
        if (FSKEW > 0) begin : g_skew
            fp_flags_t [FSKEW-1:0] skew_q, skew_d;

            always_comb begin
                skew_d = skew_q;
                if (ce) begin
                    skew_d[0] = mul_flags;
                    for (int i = 1; i < FSKEW; i++) begin
                        skew_d[i] = skew_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skew_q <= '0;
                end else begin
                    skew_q <= skew_d;
                end
            end

            assign res_flags = skew_q[FSKEW-1];
        end else begin : g_noskew
            assign res_flags = mul_flags;
        end
    endgenerate

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter (NREQ=4, LAT=8, FSKEW=1);
// arbitration expectations follow FP_MUL_ARB_RR_EN.
`timescale 1ns/1ps
module tb_fp_mul_arbiter;
    localparam int NREQ  = 4;
    localparam int LAT   = 8;
    localparam int FSKEW = 1;

    localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] FOUR = 64'h4010_0000_0000_0000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][63:0] req_a;
    logic [NREQ-1:0][63:0] req_b;
    logic [NREQ-1:0][2:0]  req_rm;
    logic                  res_valid;
    logic                  res_ready;
    logic [1:0]            res_tag;
    logic [63:0]           res_o;
    logic [3:0]            res_flags;
    logic [3:0]            inflight;

    int n_cmp;
    int n_err;

    logic [63:0] exp_o [8];
    logic [3:0]  exp_f [8];
    logic [1:0]  exp_t [8];

    fp_mul_arbiter #(
        .NREQ  (NREQ),
        .LAT   (LAT),
        .FSKEW (FSKEW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_rm    (req_rm),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_tag   (res_tag),
        .res_o     (res_o),
        .res_flags (res_flags),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] rm);
        req_valid = 4'(1 << r);
        req_a[r[1:0]]  = a;
        req_b[r[1:0]]  = b;
        req_rm[r[1:0]] = rm;
        #1;
    endtask

    task automatic goIdle();
        req_valid = '0;
        #1;
    endtask

    // Watches 40 cycles: checks n ordered results, their latency, back-to-back
    // delivery, and that nothing extra appears afterwards.
    task automatic collectResults(input string name, input int n, input int exp_first);
        int got;
        int first;
        int last;
        int extra;
        got = 0; first = -1; last = -1; extra = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (res_valid) begin
                if (got < n) begin
                    if (got == 0) first = cyc;
                    last = cyc;
                    checkOutput({name, " res_o"}, res_o, exp_o[got]);
                    checkOutput({name, " res_tag"}, 64'(res_tag), 64'(exp_t[got]));
                    checkOutput({name, " res_flags"}, 64'(res_flags), 64'(exp_f[got]));
                    got++;
                end else begin
                    extra++;
                end
            end
            tick();
        end
        checkOutput({name, " count"}, 64'(got), 64'(n));
        checkOutput({name, " first cycle"}, 64'(first), 64'(exp_first));
        checkOutput({name, " back-to-back"}, 64'(last - first), 64'(n - 1));
        checkOutput({name, " extra results"}, 64'(extra), 64'd0);
        checkOutput({name, " inflight drained"}, 64'(inflight), 64'd0);
    endtask

    initial begin
        logic [15:0] hi_in  [8];
        logic [15:0] hi_out [8];
        logic [63:0] op_a   [8];
        logic [63:0] op_b   [8];
        logic [2:0]  op_rm  [8];
        int stale;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        req_rm = '0;
        res_ready = 1'b1;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset inflight", 64'(inflight), 64'd0);

        $display("[TB] arbitration with multiple requesters");
        for (int r = 0; r < NREQ; r++) begin
            req_a[r] = ONE;
            req_b[r] = ONE;
        end
`ifdef FP_MUL_ARB_RR_EN
        req_valid = 4'b1111;
`else
        req_valid = 4'b1010;
`endif
        rst_n = 1'b1;
        #1;
        for (int t = 0; t < 8; t++) begin
`ifdef FP_MUL_ARB_RR_EN
            checkOutput("rr grant", 64'(req_ready), 64'(4'(1 << (t % 4))));
            exp_t[t] = 2'(t % 4);
`else
            checkOutput("fixed grant", 64'(req_ready), 64'h2);
            exp_t[t] = 2'd1;
`endif
            exp_o[t] = ONE;
            exp_f[t] = 4'h0;
            tick();
        end
        goIdle();
        collectResults("arb", 8, 0);

        $display("[TB] single op from requester 2");
        applyStimulus(2, ONE, TWO, 3'd0);
        checkOutput("single grant", 64'(req_ready), 64'h4);
        exp_o[0] = TWO; exp_t[0] = 2'd2; exp_f[0] = 4'h0;
        tick();
        goIdle();
        checkOutput("single inflight", 64'(inflight), 64'd1);
        collectResults("single", 1, LAT - 1);

        $display("[TB] back-to-back stream with rounding and exceptions");
        op_a[0] = 64'h7FE0_0000_0000_0000; op_b[0] = 64'h7FE0_0000_0000_0000; op_rm[0] = 3'd0;
        exp_o[0] = 64'h7FF0_0000_0000_0000; exp_f[0] = 4'b0110;
        op_a[1] = 64'h7FE0_0000_0000_0000; op_b[1] = 64'h7FE0_0000_0000_0000; op_rm[1] = 3'd1;
        exp_o[1] = 64'h7FEF_FFFF_FFFF_FFFF; exp_f[1] = 4'b0010;
        op_a[2] = 64'h3FF0_0000_0000_0001; op_b[2] = 64'h3FF0_0000_0000_0001; op_rm[2] = 3'd0;
        exp_o[2] = 64'h3FF0_0000_0000_0002; exp_f[2] = 4'b0000;
        op_a[3] = 64'h3FF0_0000_0000_0001; op_b[3] = 64'h3FF0_0000_0000_0001; op_rm[3] = 3'd3;
        exp_o[3] = 64'h3FF0_0000_0000_0003; exp_f[3] = 4'b0000;
        op_a[4] = 64'hC000_0000_0000_0000; op_b[4] = 64'h4008_0000_0000_0000; op_rm[4] = 3'd0;
        exp_o[4] = 64'hC018_0000_0000_0000; exp_f[4] = 4'b0000;
        op_a[5] = 64'h0000_0000_0000_0000; op_b[5] = 64'h4014_0000_0000_0000; op_rm[5] = 3'd0;
        exp_o[5] = 64'h0000_0000_0000_0000; exp_f[5] = 4'b0000;
        op_a[6] = 64'h7FF0_0000_0000_0000; op_b[6] = 64'h0000_0000_0000_0000; op_rm[6] = 3'd0;
        exp_o[6] = 64'h7FF8_0000_0000_0000; exp_f[6] = 4'b1000;
        op_a[7] = 64'h0010_0000_0000_0000; op_b[7] = 64'h3FE0_0000_0000_0000; op_rm[7] = 3'd0;
        exp_o[7] = 64'h0000_0000_0000_0000; exp_f[7] = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            exp_t[k] = 2'd0;
            applyStimulus(0, op_a[k], op_b[k], op_rm[k]);
            tick();
        end
        goIdle();
        collectResults("stream", 8, 0);

        $display("[TB] backpressure with a full pipeline");
        hi_in  = '{16'h3FF0, 16'h4000, 16'h4008, 16'h4010, 16'h4014, 16'h4018, 16'h401C, 16'h4020};
        hi_out = '{16'h4000, 16'h4010, 16'h4018, 16'h4020, 16'h4024, 16'h4028, 16'h402C, 16'h4030};
        res_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_o[k] = {hi_out[k], 48'd0};
            exp_t[k] = 2'(k % 4);
            exp_f[k] = 4'h0;
            applyStimulus(k % 4, {hi_in[k], 48'd0}, TWO, 3'd0);
            tick();
        end
        applyStimulus(3, ONE, ONE, 3'd0);
        for (int s = 0; s < 5; s++) begin
            checkOutput("stall res_valid", 64'(res_valid), 64'd1);
            checkOutput("stall res_o", res_o, exp_o[0]);
            checkOutput("stall res_tag", 64'(res_tag), 64'd0);
            checkOutput("stall req_ready", 64'(req_ready), 64'd0);
            checkOutput("stall inflight", 64'(inflight), 64'd8);
            tick();
        end
        goIdle();
        res_ready = 1'b1;
        collectResults("drain", 8, 0);

        $display("[TB] reset with operations in flight");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, ONE, ONE, 3'd0);
            tick();
        end
        goIdle();
        checkOutput("pre-reset inflight", 64'(inflight), 64'd5);
        #1;
        rst_n = 1'b0;
        applyStimulus(0, ONE, ONE, 3'd0);
        checkOutput("mid-reset res_valid", 64'(res_valid), 64'd0);
        checkOutput("mid-reset inflight", 64'(inflight), 64'd0);
        checkOutput("mid-reset req_ready", 64'(req_ready), 64'd0);
        tick();
        goIdle();
        tick();
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            if (res_valid) stale++;
            tick();
        end
        checkOutput("post-reset stale results", 64'(stale), 64'd0);
        applyStimulus(1, TWO, TWO, 3'd0);
        exp_o[0] = FOUR; exp_t[0] = 2'd1; exp_f[0] = 4'h0;
        tick();
        goIdle();
        collectResults("post-reset", 1, LAT - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
